fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage of the single-cycle processor. Holds the PC and a word-addressed instruction memory, and presents the current instruction plus its 16-bit immediate field to the sign/zero extend stage. It consumes the sign-extended immediate to form the branch target, selects the next PC, and detects a halt opcode or an out-of-range fetch through a small RUN/HALT state machine.

Parameters:
IMEM_DEPTH, 256, number of 32-bit instruction words; power of two, at least 2.
RESET_PC, 32'h0000_0000, PC value after reset; word aligned.

Ports:
clk  input  1  processor clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  when 1, PC and state hold for this cycle.
branch_taken  input  1  from control: branch AND ALU zero.
jump  input  1  J-type jump.
jump_reg  input  1  register jump (jr).
reg_target  input  32  rs value used by jump_reg.
signextend  input  32  sign-extended immediate returned from the extend stage.
imem_we  input  1  program-load write enable.
imem_waddr  input  32  program-load word index; only the low log2(IMEM_DEPTH) bits are used.
imem_wdata  input  32  program-load data.
pc  output  32  current PC.
pc_plus4  output  32  pc + 4, modulo 2^32.
instruction  output  32  word at the current PC.
immediated  output  16  instruction[15:0]; drives the extend stage.
halted  output  1  1 while in HALT.
fetch_error  output  1  sticky; set when HALT was entered because of an out-of-range fetch.

Behaviour:
- Reset (reset=1 at an edge): pc=RESET_PC, state=RUN, halted=0, fetch_error=0. Memory contents are preserved. Reset has priority over stall, imem_we and all next-PC inputs, and takes effect from any state, including mid-halt.
- Instruction read is combinational from word index pc[log2(IMEM_DEPTH)+1:2]. Out of range means pc[31:log2(IMEM_DEPTH)+2] != 0 or pc[1:0] != 0; in that case instruction=32'h0000_0000.
- immediated = instruction[15:0], combinational. The extend stage feeds signextend back within the same cycle, so there is no added latency.
- Memory write: when imem_we=1, the word is written at the clock edge. A write proceeds regardless of state, stall or reset. A write to the word currently being fetched shows the old value this cycle and the new value the cycle after.
- Next PC, evaluated in RUN with stall=0, in priority order:
  1. jump_reg -> reg_target
  2. jump -> {pc_plus4[31:28], instruction[25:0], 2'b00}
  3. branch_taken -> pc_plus4 + (signextend << 2), 32-bit wrap, carry discarded
  4. otherwise -> pc_plus4
- pc_plus4 wraps from 32'hFFFF_FFFC to 0.
- State machine:
  - RUN -> HALT at the edge where stall=0 and either (a) instruction[31:26]=6'b111111 (halt opcode) or (b) the fetch is out of range. In case (b), fetch_error is set to 1 at the same edge.
  - On entering HALT, pc does not advance; it stays at the halt instruction or faulting address.
  - HALT -> RUN only through reset.
  - In HALT, stall and all next-PC inputs are ignored; instruction continues to reflect the memory at the frozen pc.
- halted is registered and equals 1 exactly when state=HALT, i.e. from the cycle after the halt edge.
- stall=1 in RUN: pc and state hold; halt detection is suppressed for that cycle.
- Multiple next-PC selects asserted together: resolved strictly by the priority list above; no error is flagged.

Test Plan:
- Load words 0..3 = 0x2001_0005, 0x2002_0003, 0x0000_0000, 0xFC00_0000; pulse reset -> pc steps 0, 4, 8, 12; halted=1 the cycle after pc=12 is fetched; pc stays 12; fetch_error=0.
- pc=0x10 with branch_taken=1 and signextend=0xFFFF_FFFE -> next pc=0x0C. Repeat with signextend=0x0000_0003 -> next pc=0x20.
- pc=0x10 with jump=1, branch_taken=1, instruction[25:0]=0x40 -> next pc=0x100. Add jump_reg=1 with reg_target=0x44 -> next pc=0x44.
- IMEM_DEPTH=256, jump_reg to 0x400 -> instruction=0 that cycle; next edge halted=1, fetch_error=1, pc=0x400. Then reset=1 -> pc=0, halted=0, fetch_error=0, memory intact.
- stall=1 for 3 cycles while the halt opcode is being fetched -> pc holds and halted stays 0; stall=0 -> halted=1 the next cycle.
- imem_we=1 writing 0x1234_ABCD to the current word -> same-cycle instruction shows the old word and immediated shows the old low half; the next cycle shows instruction=0x1234_ABCD and immediated=0xABCD.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, word-addressed instruction memory,
// next-PC selection and a RUN/HALT controller for halt opcodes and bad fetches.
module fetch_unit #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    input  logic [31:0] signextend,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instruction,
    output logic [15:0] immediated,
    output logic        halted,
    output logic        fetch_error
);
    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_d;
    logic [31:0] pc_d;
    logic [31:0] mem [IMEM_DEPTH];
    logic        in_range;
    logic        halt_op;
    logic        fault;
    logic        unused_bits;

    // Program load is independent of state, stall and reset.
    always_ff @(posedge clk) begin
        if (imem_we)
            mem[imem_waddr[AW-1:0]] <= imem_wdata;
    end

    assign in_range    = ((pc >> (AW + 2)) == 32'd0) && (pc[1:0] == 2'b00);
    assign instruction = in_range ? mem[pc[AW+1:2]] : 32'h0000_0000;
    assign immediated  = instruction[15:0];
    assign halt_op     = (instruction[31:26] == 6'b111111);
    assign pc_plus4    = pc + 32'd4;
    assign halted      = (state == HALT);
    assign unused_bits = ^{imem_waddr[31:AW], signextend[31:30]};

    // Halt detection outranks every next-PC select so the PC freezes on the
    // offending instruction or address.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        fault   = 1'b0;
        if (state == RUN && !stall) begin
            if (!in_range) begin
                state_d = HALT;
                fault   = 1'b1;
            end else if (halt_op) begin
                state_d = HALT;
            end else if (jump_reg) begin
                pc_d = reg_target;
            end else if (jump) begin
                pc_d = {pc_plus4[31:28], instruction[25:0], 2'b00};
            end else if (branch_taken) begin
                pc_d = pc_plus4 + {signextend[29:0], 2'b00};
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= RUN;
            fetch_error <= 1'b0;
        end else begin
            pc    <= pc_d;
            state <= state_d;
            if (fault)
                fetch_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural model is compared against the
// DUT every cycle, plus literal expectations for each scenario.
module tb_fetch_unit;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, jump_reg, imem_we;
    logic [31:0] reg_target, signextend, imem_waddr, imem_wdata;
    logic [31:0] pc, pc_plus4, instruction;
    logic [15:0] immediated;
    logic        halted, fetch_error;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    logic [31:0] mmem [DEPTH];
    logic [31:0] mpc = 32'h0;
    bit          mhalt = 1'b0;
    bit          merr = 1'b0;
    bit          mvalid = 1'b0;

    fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .jump(jump), .jump_reg(jump_reg), .reg_target(reg_target),
        .signextend(signextend), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .pc(pc), .pc_plus4(pc_plus4),
        .instruction(instruction), .immediated(immediated), .halted(halted),
        .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit m_inr();
        return (mpc % 4 == 0) && (mpc < 4 * DEPTH);
    endfunction

    function automatic logic [31:0] m_ins();
        return m_inr() ? mmem[mpc / 4] : 32'h0;
    endfunction

    // Compare outputs against the model mid-cycle, then advance the model by
    // the edge that follows; return just after that edge.
    task automatic tick();
        logic [31:0] ins, p4;
        @(negedge clk);
        ins = m_ins();
        p4  = mpc + 32'd4;
        if (mvalid) begin
            chk("m_pc", pc, mpc);
            chk("m_pc4", pc_plus4, p4);
            chk("m_ins", instruction, ins);
            chk("m_imm", {16'h0, immediated}, {16'h0, ins[15:0]});
            chk("m_halted", {31'h0, halted}, {31'h0, mhalt});
            chk("m_ferr", {31'h0, fetch_error}, {31'h0, merr});
        end
        if (reset) begin
            mpc = 32'h0; mhalt = 1'b0; merr = 1'b0; mvalid = 1'b1;
        end else if (!mhalt && !stall) begin
            if (!m_inr()) begin
                mhalt = 1'b1; merr = 1'b1;
            end else if (ins[31:26] == 6'h3F) mhalt = 1'b1;
            else if (jump_reg)     mpc = reg_target;
            else if (jump)         mpc = {p4[31:28], ins[25:0], 2'b00};
            else if (branch_taken) mpc = p4 + signextend * 32'd4;
            else                   mpc = p4;
        end
        if (imem_we) mmem[imem_waddr % DEPTH] = imem_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] w);
        imem_we = 1'b1; imem_waddr = idx; imem_wdata = w;
        tick();
        imem_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic goto(input logic [31:0] a);
        jump_reg = 1'b1; reg_target = a;
        tick();
        jump_reg = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        reg_target = 32'h0; signextend = 32'h0; imem_we = 1'b0; imem_waddr = 32'h0; imem_wdata = 32'h0;

        for (int i = 0; i < DEPTH; i++) load(i, 32'h0);
        load(0, 32'h2001_0005);
        load(1, 32'h2002_0003);
        load(2, 32'h0000_0000);
        load(3, 32'hFC00_0000);
        load(4, 32'h0800_0040);
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_ferr", {31'h0, fetch_error}, 32'h0);
        reset = 1'b0;

        // sequential fetch into halt opcode
        tick(); chk("seq_pc4", pc, 32'h4);
        tick(); chk("seq_pc8", pc, 32'h8);
        tick(); chk("seq_pc12", pc, 32'hC); chk("seq_nohalt", {31'h0, halted}, 32'h0);
        tick(); chk("halt_set", {31'h0, halted}, 32'h1); chk("halt_pc", pc, 32'hC);
        chk("halt_ferr", {31'h0, fetch_error}, 32'h0);
        jump_reg = 1'b1; reg_target = 32'h40; tick();
        chk("halt_ign_pc", pc, 32'hC);
        jump_reg = 1'b0;

        // stall suppresses halt detection
        do_reset();
        repeat (3) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 32'hC);
            chk("stall_halted", {31'h0, halted}, 32'h0);
        end
        stall = 1'b0;
        tick(); chk("stall_rel_halted", {31'h0, halted}, 32'h1);

        // branches
        do_reset(); goto(32'h10); chk("jr_pc", pc, 32'h10);
        branch_taken = 1'b1; signextend = 32'hFFFF_FFFE; tick();
        chk("br_back", pc, 32'hC);
        branch_taken = 1'b0;
        do_reset(); goto(32'h10);
        branch_taken = 1'b1; signextend = 32'h0000_0003; tick();
        chk("br_fwd", pc, 32'h20);
        branch_taken = 1'b0;

        // jump priority
        do_reset(); goto(32'h10);
        chk("jmp_ins", instruction, 32'h0800_0040);
        jump = 1'b1; branch_taken = 1'b1; tick();
        chk("jmp_pc", pc, 32'h100);
        jump = 1'b0; branch_taken = 1'b0;
        do_reset(); goto(32'h10);
        jump = 1'b1; branch_taken = 1'b1; jump_reg = 1'b1; reg_target = 32'h44; tick();
        chk("jr_prio", pc, 32'h44);
        jump = 1'b0; branch_taken = 1'b0; jump_reg = 1'b0;

        // out-of-range fetch
        do_reset();
        jump_reg = 1'b1; reg_target = 32'h400; tick();
        chk("oor_pc", pc, 32'h400); chk("oor_ins", instruction, 32'h0);
        reg_target = 32'h0; tick();
        chk("oor_halted", {31'h0, halted}, 32'h1);
        chk("oor_ferr", {31'h0, fetch_error}, 32'h1);
        chk("oor_pc_hold", pc, 32'h400);
        jump_reg = 1'b0; stall = 1'b1; tick();
        chk("oor_ferr_sticky", {31'h0, fetch_error}, 32'h1);
        stall = 1'b0;
        do_reset();
        chk("oor_rst_pc", pc, 32'h0);
        chk("oor_rst_halted", {31'h0, halted}, 32'h0);
        chk("oor_rst_ferr", {31'h0, fetch_error}, 32'h0);
        chk("oor_rst_mem", instruction, 32'h2001_0005);

        // pc_plus4 wrap and misaligned fetch
        goto(32'hFFFF_FFFC);
        chk("wrap_p4", pc_plus4, 32'h0);
        tick(); chk("wrap_ferr", {31'h0, fetch_error}, 32'h1);
        do_reset(); goto(32'h6);
        chk("mis_ins", instruction, 32'h0);
        tick(); chk("mis_ferr", {31'h0, fetch_error}, 32'h1); chk("mis_pc", pc, 32'h6);

        // write to the word being fetched
        do_reset();
        stall = 1'b1; imem_we = 1'b1; imem_waddr = 32'h0; imem_wdata = 32'h1234_ABCD;
        #1;
        chk("wr_old_ins", instruction, 32'h2001_0005);
        chk("wr_old_imm", {16'h0, immediated}, 32'h0005);
        tick();
        imem_we = 1'b0;
        chk("wr_new_ins", instruction, 32'h1234_ABCD);
        chk("wr_new_imm", {16'h0, immediated}, 32'hABCD);
        load(32'h101, 32'hDEAD_0001);
        stall = 1'b0;
        goto(32'h4);
        chk("wr_alias", instruction, 32'hDEAD_0001);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
